// File: rtl/pwm_capture.sv
// pwm_capture: measures period and high time of an asynchronous PWM input in clock cycles,
// and flags an input that stops toggling for TIMEOUT cycles.
module pwm_capture #(
  parameter int unsigned  W       = 22,
  parameter logic [W-1:0] TIMEOUT = W'(3200000)
) (
  input  logic         Clk_in,
  input  logic         Rst,
  input  logic         Pwm_in,
  output logic [W-1:0] Period,
  output logic [W-1:0] High_time,
  output logic         Valid,
  output logic         Timeout,
  output logic         Level
);

  localparam logic [1:0] StArm      = 2'd0;
  localparam logic [1:0] StWaitRise = 2'd1;
  localparam logic [1:0] StHigh     = 2'd2;
  localparam logic [1:0] StLow      = 2'd3;

  // Compared with >= so that an edge winning at the last count cannot let cnt run past
  // the timeout point and wrap.
  localparam logic [W-1:0] TimeoutLast = TIMEOUT - W'(1);

  logic         sync1;
  logic         s;
  logic         s_d;
  logic         rise;
  logic         fall;
  logic [1:0]   state;
  logic [1:0]   state_d;
  logic         advance;
  logic         tick;
  logic [W-1:0] cnt;
  logic [W-1:0] hcap;

  // Two-flop synchronizer plus one delayed copy for edge detection.
  always_ff @(posedge Clk_in) begin
    if (Rst) begin
      sync1 <= 1'b0;
      s     <= 1'b0;
      s_d   <= 1'b0;
    end else begin
      sync1 <= Pwm_in;
      s     <= sync1;
      s_d   <= s;
    end
  end

  assign rise = s & ~s_d;
  assign fall = ~s & s_d;

  // Next state; a state-advancing edge takes priority over the timeout.
  always_comb begin
    state_d = state;
    advance = 1'b0;
    case (state)
      StArm: begin
        if (!s) begin
          state_d = StWaitRise;
          advance = 1'b1;
        end
      end
      StWaitRise: begin
        if (rise) begin
          state_d = StHigh;
          advance = 1'b1;
        end
      end
      StHigh: begin
        if (fall) begin
          state_d = StLow;
          advance = 1'b1;
        end
      end
      default: begin
        if (rise) begin
          state_d = StHigh;
          advance = 1'b1;
        end
      end
    endcase
    tick = !advance && (cnt >= TimeoutLast);
    if (tick) begin
      state_d = StArm;
    end
  end

  // State register.
  always_ff @(posedge Clk_in) begin
    if (Rst) begin
      state <= StArm;
    end else begin
      state <= state_d;
    end
  end

  // Counter, captured high time and measurement outputs.
  always_ff @(posedge Clk_in) begin
    if (Rst) begin
      cnt       <= '0;
      hcap      <= '0;
      Period    <= '0;
      High_time <= '0;
      Valid     <= 1'b0;
      Timeout   <= 1'b0;
      Level     <= 1'b0;
    end else begin
      Valid <= 1'b0;
      cnt   <= cnt + W'(1);
      if (tick) begin
        Timeout   <= 1'b1;
        Level     <= s;
        Period    <= '0;
        High_time <= '0;
        cnt       <= '0;
      end else begin
        if (state == StWaitRise && rise) begin
          cnt <= '0;
        end
        if (state == StHigh && fall) begin
          hcap <= cnt + W'(1);
        end
        if (state == StLow && rise) begin
          Period    <= cnt + W'(1);
          High_time <= hcap;
          Valid     <= 1'b1;
          Timeout   <= 1'b0;
          cnt       <= '0;
        end
      end
    end
  end

endmodule

// File: tb/tb_pwm_capture.sv
// tb_pwm_capture: directed plus randomized PWM waveforms, checked every cycle against a
// timestamp-based reference model of the measurement rules.
module tb_pwm_capture;

  localparam int unsigned W  = 16;
  localparam int          TO = 150;

  logic         Clk_in;
  logic         Rst;
  logic         Pwm_in;
  logic [W-1:0] Period;
  logic [W-1:0] High_time;
  logic         Valid;
  logic         Timeout;
  logic         Level;

  pwm_capture #(
    .W       (W),
    .TIMEOUT (W'(TO))
  ) dut (
    .Clk_in    (Clk_in),
    .Rst       (Rst),
    .Pwm_in    (Pwm_in),
    .Period    (Period),
    .High_time (High_time),
    .Valid     (Valid),
    .Timeout   (Timeout),
    .Level     (Level)
  );

  initial begin
    Clk_in = 1'b0;
    forever #5 Clk_in = ~Clk_in;
  end

  int vectors;
  int miscompares;
  int n;

  // Reference model: pin history seen with a 3-cycle latency, and timestamps of the
  // reference rise (base) and of the captured high time.
  bit q[$];
  int phase;  // 0 arm, 1 wait rise, 2 high, 3 low
  int base;
  int hcap_m;
  int e_per;
  int e_high;
  bit e_valid;
  bit e_to;
  bit e_lvl;

  task automatic model_edge(input bit pin, input bit rst);
    bit s;
    bit sd;
    bit rise;
    bit fall;
    bit adv;
    e_valid = 1'b0;
    if (rst) begin
      q = '{1'b0, 1'b0, 1'b0, 1'b0};
      phase = 0;
      base = n;
      hcap_m = 0;
      e_per = 0;
      e_high = 0;
      e_to = 1'b0;
      e_lvl = 1'b0;
    end else begin
      q.push_front(pin);
      void'(q.pop_back());
      s = q[2];
      sd = q[3];
      rise = s && !sd;
      fall = !s && sd;
      adv = 1'b0;
      if (phase == 0 && !s) begin
        phase = 1;
        adv = 1'b1;
      end else if (phase == 1 && rise) begin
        phase = 2;
        base = n;
        adv = 1'b1;
      end else if (phase == 2 && fall) begin
        hcap_m = n - base;
        phase = 3;
        adv = 1'b1;
      end else if (phase == 3 && rise) begin
        e_per = n - base;
        e_high = hcap_m;
        e_valid = 1'b1;
        e_to = 1'b0;
        base = n;
        phase = 2;
        adv = 1'b1;
      end
      if (!adv && (n - base) >= TO) begin
        e_to = 1'b1;
        e_lvl = s;
        e_per = 0;
        e_high = 0;
        base = n;
        phase = 0;
      end
    end
  endtask

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
    assert (got === want) else begin
      miscompares++;
      $error("FAIL %s cycle %0d: observed %0d expected %0d", tag, n, got, want);
    end
  endtask

  // One clock: drive inputs, advance model at the edge, sample 1 time unit later.
  task automatic step(input bit pin, input bit rst);
    Pwm_in = pin;
    Rst = rst;
    @(posedge Clk_in);
    #1;
    n++;
    vectors++;
    model_edge(pin, rst);
    check("valid", 32'(Valid), 32'(e_valid));
    check("period", 32'(Period), e_per);
    check("high_time", 32'(High_time), e_high);
    check("timeout", 32'(Timeout), 32'(e_to));
    check("level", 32'(Level), 32'(e_lvl));
  endtask

  task automatic wave(input int per, input int hi, input int count);
    for (int c = 0; c < count; c++) begin
      for (int i = 0; i < per; i++) begin
        step(i < hi, 1'b0);
      end
    end
  endtask

  task automatic idle(input bit lvl, input int cycles);
    for (int i = 0; i < cycles; i++) begin
      step(lvl, 1'b0);
    end
  endtask

  initial begin
    int per;
    int hi;
    vectors = 0;
    miscompares = 0;
    n = 0;
    Pwm_in = 1'b1;
    Rst = 1'b1;

    // Input high through and after reset: repeated timeouts with Level=1.
    step(1'b1, 1'b1);
    step(1'b1, 1'b1);
    idle(1'b1, 2 * TO + 40);

    // Steady 100/50 wave.
    idle(1'b0, 20);
    wave(100, 50, 4);

    // Duty change mid-stream.
    wave(100, 10, 3);
    wave(100, 90, 3);

    // Stuck low past the timeout, then resume.
    wave(100, 50, 2);
    idle(1'b0, 2 * TO + 30);
    wave(100, 50, 3);

    // Reset pulse while high.
    idle(1'b1, 20);
    step(1'b1, 1'b1);
    idle(1'b1, 29);
    idle(1'b0, 50);
    wave(100, 50, 3);

    // Fastest measurable input.
    wave(2, 1, 20);

    // Randomized waves and stalls.
    for (int k = 0; k < 10; k++) begin
      per = int'($urandom_range(60, 2));
      hi = int'($urandom_range(per - 1, 1));
      wave(per, hi, int'($urandom_range(5, 2)));
      if ($urandom_range(2, 0) == 0) begin
        idle(1'($urandom_range(1, 0)), int'($urandom_range(TO + 60, 10)));
      end
    end
    wave(37, 20, 3);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
